// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding, chip-select page.
package irq_ctrl_pkg;

  localparam int unsigned VEC_W   = 5;
  localparam int unsigned CS_IRQC = 11;

  localparam logic [2:0] IRQC_PEND   = 3'd0;
  localparam logic [2:0] IRQC_ENABLE = 3'd1;
  localparam logic [2:0] IRQC_MODE   = 3'd2;
  localparam logic [2:0] IRQC_VECTOR = 3'd3;
  localparam logic [2:0] IRQC_EOI    = 3'd4;
  localparam logic [2:0] IRQC_STATUS = 3'd5;

  typedef enum logic [1:0] {
    IRQC_IDLE = 2'd0,
    IRQC_REQ  = 2'd1,
    IRQC_SVC  = 2'd2
  } irqc_state_e;

endpackage

// File: rtl/irq_ctrl_prio.sv
// Lowest-index-first priority encoder over 32 request lines.
module prio_enc32 (
  input  logic [31:0] req,
  output logic        valid,
  output logic [4:0]  idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    valid = |req;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches/masks sources, picks a winner,
// and runs the req/ack/EOI handshake with the CPU.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NIRQ  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [NIRQ-1:0]  irq_in,
  output logic             irq_req,
  output logic [4:0]       irq_vec,
  input  logic             irq_ack
);

  logic [NIRQ-1:0] in_q, prev_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] enable_q, enable_d;
  logic [NIRQ-1:0] mode_q, mode_d;
  irqc_state_e     state_q, state_d;
  logic            irq_req_q, irq_req_d;
  // irq_vec_q only updates in REQ, so it holds the in-service index through SERVICE.
  logic [VEC_W-1:0] irq_vec_q, irq_vec_d;

  logic             win_valid;
  logic [VEC_W-1:0] win_idx;
  logic             wr;
  logic             eoi_wr;
  logic             ack_take;
  logic [NIRQ-1:0]  rise, w1c, ack_clr, edge_pend;

  assign wr     = cs & wen;
  assign eoi_wr = wr && (addr == IRQC_EOI);

  prio_enc32 u_prio (
    .req   (32'(pend_q & enable_q)),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Config writes and pending update; a new edge beats W1C and ack-clear.
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    if (wr && addr == IRQC_ENABLE) enable_d = din[NIRQ-1:0];
    if (wr && addr == IRQC_MODE)   mode_d   = din[NIRQ-1:0];
    if (wr && addr == IRQC_PEND)   w1c      = din[NIRQ-1:0];
    ack_clr   = ack_take ? (NIRQ'(1) << irq_vec_q) : '0;
    rise      = in_q & ~prev_q;
    edge_pend = (pend_q & ~(w1c | ack_clr)) | rise;
    pend_d    = (mode_q & edge_pend) | (~mode_q & in_q);
  end

  // Handshake FSM next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    irq_vec_d = irq_vec_q;
    ack_take  = 1'b0;
    case (state_q)
      IRQC_IDLE: if (win_valid) state_d = IRQC_REQ;
      IRQC_REQ: begin
        if (irq_ack) begin
          ack_take = 1'b1;
          state_d  = IRQC_SVC;
        end else if (!win_valid) begin
          state_d = IRQC_IDLE;
        end
      end
      IRQC_SVC:  if (eoi_wr) state_d = IRQC_IDLE;
      default:   state_d = IRQC_IDLE;
    endcase
    if (state_d == IRQC_REQ) irq_vec_d = win_idx;
    irq_req_d = (state_d == IRQC_REQ);
  end

  // State and register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q      <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      state_q   <= IRQC_IDLE;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
    end else begin
      in_q      <= irq_in;
      prev_q    <= in_q;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_vec = irq_vec_q;

  // Combinational read mux.
  always_comb begin
    dout = '0;
    case (addr)
      IRQC_PEND:   dout = WIDTH'(pend_q);
      IRQC_ENABLE: dout = WIDTH'(enable_q);
      IRQC_MODE:   dout = WIDTH'(mode_q);
      IRQC_VECTOR: dout = WIDTH'({win_valid, 26'd0, win_idx});
      IRQC_STATUS: dout = WIDTH'({29'd0, 2'(state_q), irq_req_q});
      default:     dout = '0;
    endcase
  end

endmodule
